// File: rtl/add1_norm_pkg.sv
// -----------------------------------------------------------------------------
// add1_norm_pkg
// Shared widths and state encoding for the radix-78 carry normalizer.
//   RADIX   : digit width in bits
//   SUM_W   : width of each partial-sum input (two digits)
//   CARRY_W : running-carry width; 3*(2^SUM_W-1) + (2^CARRY_W-1) fits in
//             SUM_W+2 bits, so the column sum never overflows
//   IDX_W   : width of the output digit index (wraps, no saturation)
// -----------------------------------------------------------------------------
package add1_norm_pkg;

  localparam int RADIX   = 78;
  localparam int SUM_W   = 2 * RADIX;
  localparam int CARRY_W = SUM_W + 2 - RADIX;
  localparam int IDX_W   = 8;

  // RUN accepts columns; FLUSH0/FLUSH1 emit the low and high halves of the
  // final carry as the two trailing digits of an operand.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    FLUSH0 = 2'd1,
    FLUSH1 = 2'd2
  } norm_state_e;

endpackage

// File: rtl/add3_column_sum.sv
// -----------------------------------------------------------------------------
// add3_column_sum
// Combinational column adder: three SUM_W-bit partial sums plus the optional
// running carry, evaluated at SUM_W+2 bits, then split into the normalized
// digit (low RADIX bits) and the outgoing carry (remaining CARRY_W bits).
// Ports:
//   i_res_0..2  : partial sums of the current column
//   i_use_carry : 0 on the first column of an operand (carry ignored)
//   i_carry     : running carry from the previous column
//   o_digit     : S[RADIX-1:0]
//   o_carry     : S >> RADIX
// -----------------------------------------------------------------------------
module add3_column_sum
  import add1_norm_pkg::*;
(
  input  logic [SUM_W-1:0]   i_res_0,
  input  logic [SUM_W-1:0]   i_res_1,
  input  logic [SUM_W-1:0]   i_res_2,
  input  logic               i_use_carry,
  input  logic [CARRY_W-1:0] i_carry,
  output logic [RADIX-1:0]   o_digit,
  output logic [CARRY_W-1:0] o_carry
);

  logic [SUM_W+1:0] w_carry_ext;
  logic [SUM_W+1:0] w_sum;

  assign w_carry_ext = i_use_carry ? {{(SUM_W+2-CARRY_W){1'b0}}, i_carry} : '0;

  assign w_sum = {2'b00, i_res_0} + {2'b00, i_res_1} + {2'b00, i_res_2} + w_carry_ext;

  assign o_digit = w_sum[RADIX-1:0];
  assign o_carry = w_sum[SUM_W+1:RADIX];

endmodule

// File: rtl/add1_carry_normalizer.sv
// -----------------------------------------------------------------------------
// add1_carry_normalizer
// Column-serial carry normalizer behind the radix-78 partial-product adder.
// Each accepted column yields one RADIX-bit digit one cycle later; after the
// column flagged last, the final carry is flushed as two extra digits, the
// second of which carries out_last. N columns -> N+2 digits, indices 0..N+1.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : column handshake (in_ready is combinational
//                           from out_ready; there is no skid buffer)
//   in_first / in_last    : operand framing
//   res_0..res_2          : SUM_W-bit partial sums of the column
//   out_valid / out_ready : digit handshake
//   out_digit, out_idx    : normalized digit and its position in the operand
//   out_last              : final (second flush) digit of the operand
// -----------------------------------------------------------------------------
module add1_carry_normalizer
  import add1_norm_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_first,
  input  logic             in_last,
  input  logic [SUM_W-1:0] res_0,
  input  logic [SUM_W-1:0] res_1,
  input  logic [SUM_W-1:0] res_2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RADIX-1:0] out_digit,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last
);

  norm_state_e        r_state,     w_state_next;
  logic [CARRY_W-1:0] r_carry,     w_carry_next;
  logic [IDX_W-1:0]   r_idx,       w_idx_next;
  logic               r_out_valid, w_out_valid_next;
  logic [RADIX-1:0]   r_out_digit, w_out_digit_next;
  logic [IDX_W-1:0]   r_out_idx,   w_out_idx_next;
  logic               r_out_last,  w_out_last_next;

  logic               w_slot_free;
  logic               w_in_xfer;
  logic [RADIX-1:0]   w_col_digit;
  logic [CARRY_W-1:0] w_col_carry;
  logic [IDX_W-1:0]   w_col_idx;

  add3_column_sum u_column_sum (
    .i_res_0     (res_0),
    .i_res_1     (res_1),
    .i_res_2     (res_2),
    .i_use_carry (!in_first),
    .i_carry     (r_carry),
    .o_digit     (w_col_digit),
    .o_carry     (w_col_carry)
  );

  // The output register can take a new digit when empty or being drained now.
  assign w_slot_free = !r_out_valid || out_ready;
  assign in_ready    = (r_state == RUN) && w_slot_free;
  assign w_in_xfer   = in_valid && in_ready;

  // A first column restarts numbering regardless of what idx held.
  assign w_col_idx = in_first ? '0 : r_idx;

  always_comb begin
    w_state_next     = r_state;
    w_carry_next     = r_carry;
    w_idx_next       = r_idx;
    w_out_digit_next = r_out_digit;
    w_out_idx_next   = r_out_idx;
    w_out_last_next  = r_out_last;
    // Drained digit clears valid; any load below re-asserts it in the same
    // cycle, giving one digit per cycle when the consumer keeps up.
    w_out_valid_next = r_out_valid && !out_ready;

    unique case (r_state)
      RUN: begin
        if (w_in_xfer) begin
          w_out_digit_next = w_col_digit;
          w_carry_next     = w_col_carry;
          w_out_valid_next = 1'b1;
          w_out_last_next  = 1'b0;
          w_out_idx_next   = w_col_idx;
          w_idx_next       = w_col_idx + IDX_W'(1);
          if (in_last) begin
            w_state_next = FLUSH0;
          end
        end
      end
      FLUSH0: begin
        if (w_slot_free) begin
          w_out_digit_next = r_carry[RADIX-1:0];
          w_out_valid_next = 1'b1;
          w_out_last_next  = 1'b0;
          w_out_idx_next   = r_idx;
          w_idx_next       = r_idx + IDX_W'(1);
          w_state_next     = FLUSH1;
        end
      end
      FLUSH1: begin
        if (w_slot_free) begin
          // Upper carry bits are few; zero-extend them to a full digit.
          w_out_digit_next = {{(2*RADIX-CARRY_W){1'b0}}, r_carry[CARRY_W-1:RADIX]};
          w_out_valid_next = 1'b1;
          w_out_last_next  = 1'b1;
          w_out_idx_next   = r_idx;
          w_carry_next     = '0;
          w_idx_next       = '0;
          w_state_next     = RUN;
        end
      end
      default: begin
        w_state_next = RUN;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= RUN;
      r_carry     <= '0;
      r_idx       <= '0;
      r_out_valid <= 1'b0;
      r_out_digit <= '0;
      r_out_idx   <= '0;
      r_out_last  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_carry     <= w_carry_next;
      r_idx       <= w_idx_next;
      r_out_valid <= w_out_valid_next;
      r_out_digit <= w_out_digit_next;
      r_out_idx   <= w_out_idx_next;
      r_out_last  <= w_out_last_next;
    end
  end

  assign out_valid = r_out_valid;
  assign out_digit = r_out_digit;
  assign out_idx   = r_out_idx;
  assign out_last  = r_out_last;

endmodule
